mod3_encoder: RTL and testbench

- Serial transmitter that pairs with the mod3_check receiver.
- Accepts a parallel DATA_W-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per clock.
- Appends 2 check bits so the transmitted (DATA_W+2)-bit value is an exact multiple of 3. A mod3_check on the same clock and reset, sampling dout every cycle, then raises flag_y after every complete frame.

---
 rtl/mod3_encoder.sv | 176 +++++++++++++++++
 tb/tb_mod3_encoder.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod3_encoder.sv
// Serial mod-3 frame encoder: shifts a DATA_W-bit word out MSB-first, then
// appends two check bits so every (DATA_W+2)-bit frame is a multiple of 3.
module mod3_encoder #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din,
  output logic              din_ready,
  output logic              dout,
  output logic              dout_valid,
  output logic              dout_sof,
  output logic              dout_last,
  output logic              busy
);

  localparam int unsigned CntW = $clog2(DATA_W + 2);

  // Counter holds the frame index of the bit currently on dout.
  localparam logic [CntW-1:0] LastDataIdx = CntW'(DATA_W - 1);
  localparam logic [CntW-1:0] FirstChkIdx = CntW'(DATA_W);
  localparam logic [CntW-1:0] LastChkIdx  = CntW'(DATA_W + 1);

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StCheck
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [1:0]        res_q, res_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              sof_q, sof_d;
  logic              last_q, last_d;

  logic              handshake;
  logic              final_beat;
  logic [1:0]        chk;

  // Residue of a bit stream after appending one bit: r' = (2r + b) mod 3.
  function automatic logic [1:0] res_next(input logic [1:0] r, input logic b);
    logic [1:0] n;
    case (r)
      2'd0:    n = b ? 2'd1 : 2'd0;
      2'd1:    n = b ? 2'd0 : 2'd2;
      2'd2:    n = b ? 2'd2 : 2'd1;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  // Check value c = (3 - r) mod 3, so value*4 + c == r + c == 0 (mod 3).
  function automatic logic [1:0] check_of(input logic [1:0] r);
    logic [1:0] c;
    case (r)
      2'd1:    c = 2'b10;
      2'd2:    c = 2'b01;
      default: c = 2'b00;
    endcase
    return c;
  endfunction

  // Ready/busy decode purely from registered state; no path from din_valid.
  always_comb begin
    final_beat = (state_q == StCheck) && (cnt_q == LastChkIdx);
    din_ready  = (state_q == StIdle) || final_beat;
    busy       = (state_q != StIdle);
    handshake  = din_valid && din_ready;
    chk        = check_of(res_q);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    dout_d  = 1'b0;
    valid_d = 1'b0;
    sof_d   = 1'b0;
    last_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (handshake) begin
          // First payload bit goes straight to the output register.
          state_d = StData;
          shreg_d = {din[DATA_W-2:0], 1'b0};
          res_d   = res_next(2'd0, din[DATA_W-1]);
          cnt_d   = '0;
          dout_d  = din[DATA_W-1];
          valid_d = 1'b1;
          sof_d   = 1'b1;
        end
      end

      StData: begin
        valid_d = 1'b1;
        if (cnt_q == LastDataIdx) begin
          // Residue already includes the payload bit now on dout.
          state_d = StCheck;
          dout_d  = chk[1];
          cnt_d   = FirstChkIdx;
        end else begin
          dout_d  = shreg_q[DATA_W-1];
          shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
          res_d   = res_next(res_q, shreg_q[DATA_W-1]);
          cnt_d   = cnt_q + CntW'(1);
        end
      end

      StCheck: begin
        if (cnt_q == FirstChkIdx) begin
          dout_d  = chk[0];
          valid_d = 1'b1;
          last_d  = 1'b1;
          cnt_d   = LastChkIdx;
        end else if (handshake) begin
          // Back-to-back frame: next sof follows this last bit directly.
          state_d = StData;
          shreg_d = {din[DATA_W-2:0], 1'b0};
          res_d   = res_next(2'd0, din[DATA_W-1]);
          cnt_d   = '0;
          dout_d  = din[DATA_W-1];
          valid_d = 1'b1;
          sof_d   = 1'b1;
        end else begin
          state_d = StIdle;
          shreg_d = '0;
          res_d   = 2'd0;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = StIdle;
        shreg_d = '0;
        res_d   = 2'd0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and registered outputs; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shreg_q <= '0;
      res_q   <= 2'd0;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      last_q  <= last_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign dout_sof   = sof_q;
  assign dout_last  = last_q;

endmodule

// File: tb/tb_mod3_encoder.sv
// Self-checking bench for mod3_encoder: fixed vectors, back-to-back frames,
// random loopback against an arithmetic frame model, and mid-frame reset.
module tb_mod3_encoder;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         din_valid;
  logic [W-1:0] din;
  logic         din_ready;
  logic         dout;
  logic         dout_valid;
  logic         dout_sof;
  logic         dout_last;
  logic         busy;

  int n_checks;
  int n_fail;

  mod3_encoder #(.DATA_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din_valid (din_valid),
    .din       (din),
    .din_ready (din_ready),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_sof  (dout_sof),
    .dout_last (dout_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference frame value: word*4 + (3 - word mod 3) mod 3.
  function automatic logic [63:0] frame_value(input logic [W-1:0] w);
    int r;
    int c;
    r = int'(w) % 3;
    c = (3 - r) % 3;
    return 64'(w) * 64'd4 + 64'(c);
  endfunction

  // Records n cycles of outputs, one bit per cycle, starting with the current one.
  task automatic capture(input int n, output logic [63:0] d, output logic [63:0] s,
                         output logic [63:0] l, output logic [63:0] v,
                         output logic [63:0] r, output logic [63:0] b);
    d = '0; s = '0; l = '0; v = '0; r = '0; b = '0;
    for (int i = 0; i < n; i++) begin
      d[i] = dout; s[i] = dout_sof; l[i] = dout_last;
      v[i] = dout_valid; r[i] = din_ready; b[i] = busy;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; din_valid = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({dout, dout_valid, dout_sof, dout_last, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 00000",
               {dout, dout_valid, dout_sof, dout_last, busy});
    end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (din_ready !== 1'b1 || dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b valid=%b want ready=1 valid=0",
               din_ready, dout_valid);
    end
  endtask

  task automatic test_known_vectors();
    logic [W-1:0] words [7];
    logic [63:0]  fv, ed, d, s, l, v, r, b;
    words[0] = 8'h09; words[1] = 8'h07; words[2] = 8'h05; words[3] = 8'hFF;
    words[4] = W'($urandom); words[5] = W'($urandom); words[6] = 8'h00;
    for (int n = 0; n < 7; n++) begin
      fv = frame_value(words[n]);
      ed = '0;
      for (int k = 0; k < W + 2; k++) ed[k] = fv[W+1-k];
      din = words[n]; din_valid = 1'b1;
      @(posedge clk); #1;
      din_valid = 1'b0; din = W'($urandom);
      capture(W + 3, d, s, l, v, r, b);
      n_checks++;
      if (d !== ed) begin
        n_fail++;
        $display("FAIL known_dout[%h]: got %h want %h", words[n], d, ed);
      end
      n_checks++;
      if (v !== ((64'd1 << (W + 2)) - 1) || b !== v) begin
        n_fail++;
        $display("FAIL known_valid[%h]: valid %h busy %h want %h", words[n], v, b,
                 (64'd1 << (W + 2)) - 1);
      end
      n_checks++;
      if (s !== 64'd1 || l !== (64'd1 << (W + 1))) begin
        n_fail++;
        $display("FAIL known_sof_last[%h]: sof %h last %h want 1 / %h", words[n], s, l,
                 64'd1 << (W + 1));
      end
      n_checks++;
      if (r !== ((64'd1 << (W + 1)) | (64'd1 << (W + 2)))) begin
        n_fail++;
        $display("FAIL known_ready[%h]: got %h want %h", words[n], r,
                 (64'd1 << (W + 1)) | (64'd1 << (W + 2)));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] f1, f2, ed, d, s, l, v, r;
    logic        ready_now;
    int          hs;
    f1 = frame_value(8'h07);
    f2 = frame_value(8'h05);
    ed = '0;
    for (int k = 0; k < W + 2; k++) begin
      ed[k]         = f1[W+1-k];
      ed[k + W + 2] = f2[W+1-k];
    end
    d = '0; s = '0; l = '0; v = '0; r = '0; hs = 0;
    din = 8'h07; din_valid = 1'b1;
    for (int c = 0; c < 2 * W + 6; c++) begin
      ready_now = din_ready;
      @(posedge clk); #1;
      if (ready_now && din_valid) begin
        hs++;
        if (hs == 1) din = 8'h05;
        else begin
          din_valid = 1'b0; din = W'($urandom);
        end
      end
      d[c] = dout; s[c] = dout_sof; l[c] = dout_last; v[c] = dout_valid; r[c] = din_ready;
    end
    n_checks++;
    if (hs !== 2) begin
      n_fail++;
      $display("FAIL b2b_handshakes: got %0d want 2", hs);
    end
    n_checks++;
    if (d !== ed || v !== ((64'd1 << (2 * W + 4)) - 1)) begin
      n_fail++;
      $display("FAIL b2b_stream: dout %h valid %h want %h / %h", d, v, ed,
               (64'd1 << (2 * W + 4)) - 1);
    end
    n_checks++;
    if (s !== (64'd1 | (64'd1 << (W + 2))) ||
        l !== ((64'd1 << (W + 1)) | (64'd1 << (2 * W + 3)))) begin
      n_fail++;
      $display("FAIL b2b_sof_last: sof %h last %h", s, l);
    end
    n_checks++;
    if (r !== ((64'd1 << (W + 1)) | (64'd7 << (2 * W + 3)))) begin
      n_fail++;
      $display("FAIL b2b_ready: got %h want %h", r,
               (64'd1 << (W + 1)) | (64'd7 << (2 * W + 3)));
    end
  endtask

  task automatic test_din_toggle();
    logic [63:0] fv, ed, d, v;
    fv = frame_value(8'h3C);
    ed = '0;
    for (int k = 0; k < W + 2; k++) ed[k] = fv[W+1-k];
    d = '0; v = '0;
    din = 8'h3C; din_valid = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < W + 3; c++) begin
      d[c] = dout; v[c] = dout_valid;
      if (din_ready) din_valid = 1'b0;
      else din = W'($urandom);
      @(posedge clk); #1;
    end
    n_checks++;
    if (d !== ed || v !== ((64'd1 << (W + 2)) - 1)) begin
      n_fail++;
      $display("FAIL din_toggle: dout %h valid %h want %h / %h", d, v, ed,
               (64'd1 << (W + 2)) - 1);
    end
  endtask

  task automatic test_random_loopback();
    logic [2:0]   exp_q[$];
    logic [2:0]   e;
    logic [63:0]  fv;
    logic [W-1:0] word;
    logic         hs;
    int           sent, gap, acc, bad;
    bit           done;
    sent = 0; acc = 0; bad = 0; done = 0;
    gap = $urandom_range(0, 3);
    din_valid = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      if (!din_valid && sent < 200) begin
        if (gap == 0) begin
          din = W'($urandom); din_valid = 1'b1;
        end else gap--;
      end else if (din_valid && !din_ready) begin
        din = W'($urandom);
      end
      hs = din_valid && din_ready;
      word = din;
      @(posedge clk); #1;
      if (hs) begin
        fv = frame_value(word);
        for (int k = 0; k < W + 2; k++) exp_q.push_back({fv[W+1-k], k == 0, k == W + 1});
        sent++;
        din_valid = 1'b0; din = W'($urandom);
        gap = $urandom_range(0, 3);
      end
      // Continuously sampling checker: residue of the whole stream so far.
      acc = (2 * acc + int'(dout)) % 3;
      if (dout_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; bad++;
          $display("FAIL rand_unexpected_valid: cycle %0d", c);
        end else begin
          e = exp_q.pop_front();
          if ({dout, dout_sof, dout_last} !== e) begin
            n_fail++; bad++;
            if (bad < 10) $display("FAIL rand_bit: cycle %0d got %b want %b", c,
                                   {dout, dout_sof, dout_last}, e);
          end
        end
        if (dout_last) begin
          n_checks++;
          if (acc != 0) begin
            n_fail++;
            $display("FAIL rand_flag_at_last: cycle %0d residue %0d want 0", c, acc);
          end
        end
      end else begin
        n_checks++;
        if (exp_q.size() != 0 || {dout, dout_sof, dout_last} !== 3'b0 || acc != 0) begin
          n_fail++; bad++;
          if (bad < 10) $display("FAIL rand_idle: cycle %0d pending %0d outs %b residue %0d",
                                 c, exp_q.size(), {dout, dout_sof, dout_last}, acc);
        end
      end
      if (sent == 200 && exp_q.size() == 0 && !dout_valid && !din_valid) done = 1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL rand_timeout: sent %0d pending %0d want 200 / 0", sent, exp_q.size());
    end
  endtask

  task automatic test_reset_midframe();
    logic [63:0] fv, ed, d, s, l, v, r, b;
    din = 8'hA5; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    // 0xA5 = 1010_0101: fourth bit sent is 0.
    n_checks++;
    if (dout !== 1'b0 || dout_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_bit4: dout=%b valid=%b want 0/1", dout, dout_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({dout, dout_valid, dout_sof, dout_last, busy, din_ready} !== 6'b000001) begin
      n_fail++;
      $display("FAIL midreset_async: got %b want 000001",
               {dout, dout_valid, dout_sof, dout_last, busy, din_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (din_ready !== 1'b1 || dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_release: ready=%b valid=%b want 1/0", din_ready, dout_valid);
    end
    fv = frame_value(8'h03);
    ed = '0;
    for (int k = 0; k < W + 2; k++) ed[k] = fv[W+1-k];
    din = 8'h03; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    capture(W + 3, d, s, l, v, r, b);
    n_checks++;
    if (d !== ed || v !== ((64'd1 << (W + 2)) - 1) || s !== 64'd1) begin
      n_fail++;
      $display("FAIL midreset_next_frame: dout %h valid %h sof %h want %h", d, v, s, ed);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_known_vectors();
    test_back_to_back();
    test_din_toggle();
    test_random_loopback();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
